unified_mem_responder: RTL and testbench

UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

---
 rtl/unified_mem_responder.sv | 147 ++++++++++++++
 tb/tb_unified_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_responder.sv
// rtl/unified_mem_responder.sv - two-port (fetch/data) word memory with fixed-latency responses
// Round-robin grant in IDLE, stores commit on the grant edge, loads are extracted at grant and held until RESP.
module unified_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [2:0]  d_funct3_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LAST = 3'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic        last_if_q;
    logic        resp_if_q;
    logic        resp_err_q;
    logic [31:0] resp_data_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          idle_d;
    logic          gnt_d_d;
    logic          gnt_if_d;
    logic [AW-1:0] d_idx_d;
    logic [AW-1:0] if_idx_d;
    logic [31:0]   d_word_d;
    logic [31:0]   d_shift_d;
    logic          d_bad_d;
    logic [31:0]   load_val_d;
    logic [31:0]   d_result_d;
    logic [3:0]    wmask_d;
    logic [31:0]   wlane_d;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{d_addr_i[31:AW+2], if_addr_i[31:AW+2], if_addr_i[1:0]};

    // Data port wins a tie only when fetch was granted last.
    assign idle_d   = (state_q == IDLE) && !rst_i;
    assign gnt_d_d  = idle_d && d_req_i && (!if_req_i || last_if_q);
    assign gnt_if_d = idle_d && if_req_i && !gnt_d_d;
    assign if_gnt_o = gnt_if_d;
    assign d_gnt_o  = gnt_d_d;
    assign busy_o   = (state_q != IDLE);

    assign d_idx_d   = d_addr_i[AW+1:2];
    assign if_idx_d  = if_addr_i[AW+1:2];
    assign d_word_d  = mem_q[d_idx_d];
    assign d_shift_d = d_word_d >> {d_addr_i[1:0], 3'b000};

    always_comb begin
        d_bad_d    = 1'b0;
        load_val_d = 32'h0;
        wmask_d    = 4'b0000;
        wlane_d    = d_wdata_i;
        case (d_funct3_i)
            3'b000: begin
                load_val_d = {{24{d_shift_d[7]}}, d_shift_d[7:0]};
                wmask_d    = 4'b0001 << d_addr_i[1:0];
                wlane_d    = {4{d_wdata_i[7:0]}};
            end
            3'b001: begin
                d_bad_d    = d_addr_i[0];
                load_val_d = {{16{d_shift_d[15]}}, d_shift_d[15:0]};
                wmask_d    = d_addr_i[1] ? 4'b1100 : 4'b0011;
                wlane_d    = {2{d_wdata_i[15:0]}};
            end
            3'b010: begin
                d_bad_d    = (d_addr_i[1:0] != 2'b00);
                load_val_d = d_word_d;
                wmask_d    = 4'b1111;
            end
            3'b100: begin
                d_bad_d    = d_we_i;
                load_val_d = {24'h0, d_shift_d[7:0]};
            end
            3'b101: begin
                d_bad_d    = d_we_i || d_addr_i[0];
                load_val_d = {16'h0, d_shift_d[15:0]};
            end
            default: d_bad_d = 1'b1;
        endcase
    end

    assign d_result_d = (d_we_i || d_bad_d) ? 32'h0 : load_val_d;

    // Storage has no reset; it only changes on an accepted, legal store.
    always_ff @(posedge clk_i) begin
        if (gnt_d_d && d_we_i && !d_bad_d) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_d[b]) mem_q[d_idx_d][8*b +: 8] <= wlane_d[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            last_if_q   <= 1'b1;
            resp_if_q   <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_data_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_d_d || gnt_if_d) begin
                        last_if_q   <= gnt_if_d;
                        resp_if_q   <= gnt_if_d;
                        resp_err_q  <= gnt_d_d && d_bad_d;
                        resp_data_q <= gnt_if_d ? mem_q[if_idx_d] : d_result_d;
                        cnt_q       <= 3'd0;
                        state_q     <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_LAST) state_q <= RESP;
                    else cnt_q <= cnt_q + 3'd1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rvalid_o = (state_q == RESP) && resp_if_q;
    assign d_rvalid_o  = (state_q == RESP) && !resp_if_q;
    assign if_rdata_o  = if_rvalid_o ? resp_data_q : 32'h0;
    assign d_rdata_o   = d_rvalid_o ? resp_data_q : 32'h0;
    assign d_err_o     = d_rvalid_o && resp_err_q;
endmodule

// File: tb/tb_unified_mem_responder.sv
// tb/tb_unified_mem_responder.sv - directed vector bench for unified_mem_responder
module tb_unified_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err, busy;
    logic [31:0] d_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_funct3_i(d_funct3), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
        .d_rdata_o(d_rdata), .d_err_o(d_err), .busy_o(busy)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic data_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rd,
                               output logic er, output int lat);
        int n = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
        #1;
        while (!d_gnt && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) chk("d_gnt timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!d_rvalid && lat < 20);
        rd = d_rdata;
        er = d_err;
        chk("if_rvalid during data resp", {31'd0, if_rvalid}, 32'd0);
    endtask

    task automatic reset_in_wait(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_funct3 = 3'b010; d_addr = addr; d_wdata = wdata;
        #1;
        while (!d_gnt && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) chk("rst-wait gnt timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("busy in WAIT", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("busy during rst", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no rvalid after rst", {30'd0, d_rvalid, if_rvalid}, 32'd0);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          gcyc[$];
    int          gkind[$];

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{1'b0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b0, 3'b100, 32'h12,  32'h0,        32'h000000AD, 1'b0};
        vecs[7]  = '{1'b1, 3'b010, 32'h20,  32'hCAFEF00D, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 3'b001, 32'h21,  32'h00001111, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 3'b010, 32'h22,  32'h22222222, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 3'b011, 32'h20,  32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b0, 3'b010, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0};
        vecs[12] = '{1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 3'b010, 32'h000, 32'h0,        32'h12345678, 1'b0};
        vecs[14] = '{1'b1, 3'b000, 32'h21,  32'hFFFFFFAB, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 3'b010, 32'h20,  32'h0,        32'hCAFEAB0D, 1'b0};
        vecs[16] = '{1'b1, 3'b001, 32'h22,  32'hFFFF1234, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 3'b010, 32'h20,  32'h0,        32'h1234AB0D, 1'b0};
        vecs[18] = '{1'b1, 3'b100, 32'h20,  32'h99999999, 32'h0,        1'b1};
        vecs[19] = '{1'b0, 3'b010, 32'h20,  32'h0,        32'h1234AB0D, 1'b0};
        vecs[20] = '{1'b0, 3'b001, 32'h11,  32'h0,        32'h0,        1'b1};
        vecs[21] = '{1'b0, 3'b010, 32'h13,  32'h0,        32'h0,        1'b1};

        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        d_req = 1'b1; if_req = 1'b1;
        #1;
        chk("reset gnt", {30'd0, d_gnt, if_gnt}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rvalid/err", {29'd0, d_rvalid, if_rvalid, d_err}, 32'd0);
        chk("reset d_rdata", d_rdata, 32'h0);
        chk("reset if_rdata", if_rdata, 32'h0);
        d_req = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            data_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d latency", i), lat, 32'd2);
        end

        // Fetch ignores low address bits and wraps like the data port.
        begin
            int n = 0;
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h403;
            #1;
            while (!if_gnt && n < 20) begin @(negedge clk); #1; n++; end
            if (n >= 20) chk("if_gnt timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            if_req = 1'b0;
            lat = 0;
            do begin @(negedge clk); lat++; end while (!if_rvalid && lat < 20);
            chk("fetch rdata", if_rdata, 32'h12345678);
            chk("fetch latency", lat, 32'd2);
            chk("fetch d_rvalid", {31'd0, d_rvalid}, 32'd0);
        end

        // Both ports held high from reset: strict alternation starting with data.
        @(negedge clk);
        rst = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h13;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d_gnt && if_gnt) chk("double gnt", 32'd1, 32'd0);
            if (d_gnt) begin gcyc.push_back(c); gkind.push_back(0); end
            if (if_gnt) begin gcyc.push_back(c); gkind.push_back(1); end
            if (if_rvalid) chk("alt fetch rdata", if_rdata, 32'hDEADBEEF);
            if (d_rvalid) chk("alt load rdata", d_rdata, 32'hDEADBEEF);
        end
        d_req = 1'b0; if_req = 1'b0;
        chk("alt grant count", gcyc.size(), 32'd4);
        for (int k = 0; k < gcyc.size() && k < 4; k++) begin
            chk($sformatf("alt grant%0d cycle", k), gcyc[k], 3 * k);
            chk($sformatf("alt grant%0d port", k), gkind[k], k % 2);
        end

        // Reset in WAIT drops the response but keeps a committed store.
        reset_in_wait(1'b0, 32'h10, 32'h0);
        data_access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        chk("post-rst load rdata", rd, 32'hDEADBEEF);
        chk("post-rst load latency", lat, 32'd2);
        reset_in_wait(1'b1, 32'h30, 32'h55AA55AA);
        data_access(1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
        chk("store kept across rst", rd, 32'h55AA55AA);
        chk("store kept err", {31'd0, er}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
